// File: rtl/cellram_ctrl_pkg.sv
// Shared definitions for the CellularRAM async-mode controller: FSM states,
// default device timing (cycles at 50 MHz) and the latched request record.
package cellram_ctrl_pkg;

    localparam int RD_CYC_DEF    = 5;
    localparam int WR_CYC_DEF    = 5;
    localparam int REC_CYC_DEF   = 1;
    localparam int PWRUP_CYC_DEF = 7500;

    localparam int TMR_W = 4;
    localparam int PWR_W = 13;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_RD_ACC,
        ST_WR_SET,
        ST_WR_PUL,
        ST_WR_HLD,
        ST_REC,
        ST_ACK
    } state_e;

    // hwa is the word address adr[23:2]; the halfword select is appended later
    typedef struct packed {
        logic [21:0] hwa;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } req_t;

    function automatic logic is_acc(input state_e s);
        return s inside {ST_RD_ACC, ST_WR_SET, ST_WR_PUL, ST_WR_HLD};
    endfunction

endpackage

// File: rtl/cellram_ctrl_if.sv
// Wishbone classic slave-side signal bundle for cellram_ctrl.
interface cellram_ctrl_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/cellram_ctrl_cyc_timer.sv
// Loadable 4-bit down-counter; done_o is high while the count is zero.
// Loading N-1 on phase entry gives a phase lasting exactly N cycles.
module cellram_cyc_timer
    import cellram_ctrl_pkg::*;
(
    input  logic             wb_clk,
    input  logic             wb_rst,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             done_o
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - TMR_W'(1);
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/cellram_ctrl.sv
// Wishbone classic slave driving a 16-bit CellularRAM in async mode; each 32-bit
// access becomes 1-2 timed halfword cycles, high half first. Option: CELLRAM_PWRUP_WAIT_EN.
module cellram_ctrl
    import cellram_ctrl_pkg::*;
#(
    parameter int RD_CYC    = RD_CYC_DEF,
    parameter int WR_CYC    = WR_CYC_DEF,
    parameter int REC_CYC   = REC_CYC_DEF
`ifdef CELLRAM_PWRUP_WAIT_EN
   ,parameter int PWRUP_CYC = PWRUP_CYC_DEF
`endif
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    cellram_ctrl_if.slave wb,
    output logic [22:0]   mem_addr,
    input  logic [15:0]   mem_dq_i,
    output logic [15:0]   mem_dq_o,
    output logic          mem_dq_oe,
    output logic          mem_ce_n,
    output logic          mem_oe_n,
    output logic          mem_we_n,
    output logic          mem_lb_n,
    output logic          mem_ub_n,
    output logic          mem_adv_n,
    output logic          mem_cre,
    output logic          mem_clk
);

    state_e           state_q, state_d;
    req_t             req_q, req_d;
    logic             half_q, half_d;
    logic             more_q, more_d;
    logic             abort_q, abort_d;
    logic [31:0]      rbuf_q, rbuf_d;
    logic             req_now, abort_now, half_end, pwr_done;
    logic             tmr_load, tmr_done;
    logic [TMR_W-1:0] tmr_val;
    logic [1:0]       hsel_d;
    logic             start_acc;

    logic             ack_q, dq_oe_q, ce_n_q, oe_n_q, we_n_q, lb_n_q, ub_n_q;
    logic [31:0]      dat_o_q;
    logic [22:0]      addr_q;
    logic [15:0]      dq_q;

    logic             unused_adr;
    assign unused_adr = ^{wb.wb_adr_i[31:24], wb.wb_adr_i[1:0]};

`ifdef CELLRAM_PWRUP_WAIT_EN
    localparam state_e RST_STATE = ST_PWRUP;
    logic [PWR_W-1:0] pwr_cnt_q;

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst)
            pwr_cnt_q <= PWR_W'(PWRUP_CYC - 1);
        else if (state_q == ST_PWRUP && pwr_cnt_q != '0)
            pwr_cnt_q <= pwr_cnt_q - PWR_W'(1);
    end

    assign pwr_done = (pwr_cnt_q == '0);
`else
    localparam state_e RST_STATE = ST_IDLE;
    assign pwr_done = 1'b1;
`endif

    assign req_now   = wb.wb_cyc_i & wb.wb_stb_i;
    // once stb has dropped during a transfer the transfer is abandoned for good
    assign abort_now = abort_q | ~req_now;

    cellram_cyc_timer u_tmr (
        .wb_clk     (wb_clk),
        .wb_rst     (wb_rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    // every timed phase is entered from a different state, so a state change reloads
    assign tmr_load = (state_d != state_q);

    always_comb begin
        tmr_val = '0;
        case (state_d)
            ST_RD_ACC: tmr_val = TMR_W'(RD_CYC - 1);
            ST_WR_PUL: tmr_val = TMR_W'(WR_CYC - 1);
            ST_REC:    tmr_val = TMR_W'(REC_CYC - 1);
            default:   tmr_val = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        half_d   = half_q;
        more_d   = more_q;
        abort_d  = abort_q;
        rbuf_d   = rbuf_q;
        half_end = 1'b0;

        if (!(state_q inside {ST_IDLE, ST_PWRUP}))
            abort_d = abort_now;

        unique case (state_q)
            ST_PWRUP: if (pwr_done) state_d = ST_IDLE;
            ST_IDLE: begin
                if (req_now) begin
                    req_d.hwa = wb.wb_adr_i[23:2];
                    req_d.dat = wb.wb_dat_i;
                    req_d.sel = wb.wb_sel_i;
                    req_d.we  = wb.wb_we_i;
                    abort_d   = 1'b0;
                    more_d    = 1'b0;
                    rbuf_d    = '0;
                    half_d    = ~|wb.wb_sel_i[3:2];
                    if (wb.wb_sel_i == 4'h0)
                        state_d = ST_ACK;
                    else
                        state_d = wb.wb_we_i ? ST_WR_SET : ST_RD_ACC;
                end
            end
            ST_RD_ACC: begin
                if (tmr_done) begin
                    if (half_q)
                        rbuf_d[15:0]  = mem_dq_i;
                    else
                        rbuf_d[31:16] = mem_dq_i;
                    half_end = 1'b1;
                end
            end
            ST_WR_SET: state_d = ST_WR_PUL;
            ST_WR_PUL: if (tmr_done) state_d = ST_WR_HLD;
            ST_WR_HLD: half_end = 1'b1;
            ST_REC: begin
                if (tmr_done) begin
                    more_d = 1'b0;
                    if (more_q && !abort_now) begin
                        half_d  = 1'b1;
                        state_d = req_q.we ? ST_WR_SET : ST_RD_ACC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_ACK: state_d = ST_REC;
        endcase

        if (half_end) begin
            if (abort_now) begin
                more_d  = 1'b0;
                state_d = ST_REC;
            end else if (!half_q && |req_q.sel[1:0]) begin
                more_d  = 1'b1;
                state_d = ST_REC;
            end else begin
                state_d = ST_ACK;
            end
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q <= RST_STATE;
            req_q   <= '0;
            half_q  <= 1'b0;
            more_q  <= 1'b0;
            abort_q <= 1'b0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            half_q  <= half_d;
            more_q  <= more_d;
            abort_q <= abort_d;
            rbuf_q  <= rbuf_d;
        end
    end

    // Pads are registered from the next state so they line up with the state itself
    assign start_acc = is_acc(state_d) && !is_acc(state_q);
    assign hsel_d    = half_d ? req_d.sel[1:0] : req_d.sel[3:2];

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            ack_q   <= 1'b0;
            dat_o_q <= '0;
            addr_q  <= '0;
            dq_q    <= '0;
            dq_oe_q <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
        end else begin
            ack_q   <= (state_d == ST_ACK);
            dq_oe_q <= state_d inside {ST_WR_SET, ST_WR_PUL, ST_WR_HLD};
            ce_n_q  <= !is_acc(state_d);
            oe_n_q  <= (state_d != ST_RD_ACC);
            we_n_q  <= (state_d != ST_WR_PUL);
            if (start_acc) begin
                addr_q <= {req_d.hwa, half_d};
                dq_q   <= half_d ? req_d.dat[15:0] : req_d.dat[31:16];
                ub_n_q <= ~hsel_d[1];
                lb_n_q <= ~hsel_d[0];
            end else if (!is_acc(state_d)) begin
                ub_n_q <= 1'b1;
                lb_n_q <= 1'b1;
            end
            if (state_d == ST_ACK && !req_d.we)
                dat_o_q <= rbuf_d;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_o_q;
    assign mem_addr    = addr_q;
    assign mem_dq_o    = dq_q;
    assign mem_dq_oe   = dq_oe_q;
    assign mem_ce_n    = ce_n_q;
    assign mem_oe_n    = oe_n_q;
    assign mem_we_n    = we_n_q;
    assign mem_lb_n    = lb_n_q;
    assign mem_ub_n    = ub_n_q;
    assign mem_adv_n   = 1'b0;
    assign mem_cre     = 1'b0;
    assign mem_clk     = 1'b0;

endmodule

// File: tb/tb_cellram_ctrl.sv
// Directed bench for cellram_ctrl with a 64-halfword device model that honours
// oe_n/we_n and the byte lanes; a negedge monitor counts strobe activity.
module tb_cellram_ctrl;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic [22:0] mem_addr;
    logic [15:0] mem_dq_i, mem_dq_o;
    logic        mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n;
    logic        mem_adv_n, mem_cre, mem_clk;

    int n_cmp = 0;
    int n_err = 0;

    always #5 wb_clk = ~wb_clk;

    cellram_ctrl_if wb ();

    cellram_ctrl dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .wb        (wb),
        .mem_addr  (mem_addr),
        .mem_dq_i  (mem_dq_i),
        .mem_dq_o  (mem_dq_o),
        .mem_dq_oe (mem_dq_oe),
        .mem_ce_n  (mem_ce_n),
        .mem_oe_n  (mem_oe_n),
        .mem_we_n  (mem_we_n),
        .mem_lb_n  (mem_lb_n),
        .mem_ub_n  (mem_ub_n),
        .mem_adv_n (mem_adv_n),
        .mem_cre   (mem_cre),
        .mem_clk   (mem_clk)
    );

    logic [15:0] mem [0:63];

    assign mem_dq_i = (mem_oe_n === 1'b0) ? mem[mem_addr[5:0]] : 16'h0000;

    always @(posedge mem_we_n) begin
        if (!wb_rst && mem_ce_n === 1'b0) begin
            if (!mem_ub_n) mem[mem_addr[5:0]][15:8] = mem_dq_o[15:8];
            if (!mem_lb_n) mem[mem_addr[5:0]][7:0]  = mem_dq_o[7:0];
        end
    end

    int          ce_falls, oe_lo, we_lo, stab_err;
    logic        prev_ce_n = 1'b1;
    logic [22:0] acc_addr;
    logic        acc_ub_n, acc_lb_n;
    logic [15:0] acc_dq;

    always @(negedge wb_clk) begin
        if (!wb_rst) begin
            if (mem_oe_n === 1'b0) oe_lo++;
            if (mem_we_n === 1'b0) we_lo++;
            if (mem_ce_n === 1'b0) begin
                if (prev_ce_n) begin
                    ce_falls++;
                    acc_addr = mem_addr;
                    acc_ub_n = mem_ub_n;
                    acc_lb_n = mem_lb_n;
                    acc_dq   = mem_dq_o;
                end else if ({mem_addr, mem_ub_n, mem_lb_n, mem_dq_o} !==
                             {acc_addr, acc_ub_n, acc_lb_n, acc_dq}) begin
                    stab_err++;
                end
            end
            prev_ce_n = (mem_ce_n !== 1'b0);
        end else begin
            prev_ce_n = 1'b1;
        end
    end

    // Cycle 0 is the cycle the request is first presented; ack_cyc stays -1 when no ack arrives within budget.
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input int drop_at, input int budget,
                           output int ack_cyc, output logic [31:0] rdat);
        ce_falls = 0; oe_lo = 0; we_lo = 0; stab_err = 0;
        ack_cyc = -1;
        rdat = '0;
        @(posedge wb_clk); #1;
        wb.wb_adr_i = adr; wb.wb_dat_i = dat; wb.wb_sel_i = sel; wb.wb_we_i = we;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        for (int k = 0; k < budget; k++) begin
            if (k == drop_at) begin
                wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
            end
            @(negedge wb_clk);
            if (wb.wb_ack_o === 1'b1) begin
                ack_cyc = k;
                rdat = wb.wb_dat_o;
                @(posedge wb_clk); #1;
                break;
            end
            @(posedge wb_clk); #1;
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge wb_clk);
        #1;
        n_cmp++; if (wb.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b expected 0", wb.wb_ack_o); end
        n_cmp++; if (wb.wb_dat_o !== 32'h0) begin n_err++; $display("FAIL rst_dat: got %h expected 0", wb.wb_dat_o); end
        n_cmp++; if ({mem_addr, mem_dq_o, mem_dq_oe} !== 40'h0) begin n_err++; $display("FAIL rst_addr_dq: got %h/%h/%b expected 0", mem_addr, mem_dq_o, mem_dq_oe); end
        n_cmp++; if ({mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n} !== 5'b11111) begin n_err++; $display("FAIL rst_strobes: got %b expected 11111", {mem_ce_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n}); end
        n_cmp++; if ({mem_adv_n, mem_cre, mem_clk} !== 3'b000) begin n_err++; $display("FAIL rst_const: got %b expected 000", {mem_adv_n, mem_cre, mem_clk}); end
        @(negedge wb_clk);
        wb_rst = 1'b0;
`ifdef CELLRAM_PWRUP_WAIT_EN
        repeat (7600) @(posedge wb_clk);
`endif
    endtask

    task automatic test_read_full();
        int ack; logic [31:0] rd;
        wb_xfer(1'b0, 32'h0000_0010, 32'h0, 4'hF, -1, 60, ack, rd);
        n_cmp++; if (ack !== 12) begin n_err++; $display("FAIL rd_full_ack: got %0d expected 12", ack); end
        n_cmp++; if (rd !== 32'h1234_ABCD) begin n_err++; $display("FAIL rd_full_dat: got %h expected 1234abcd", rd); end
        n_cmp++; if (oe_lo !== 10) begin n_err++; $display("FAIL rd_full_oe: got %0d expected 10", oe_lo); end
        n_cmp++; if (ce_falls !== 2) begin n_err++; $display("FAIL rd_full_ce: got %0d expected 2", ce_falls); end
        n_cmp++; if (stab_err !== 0) begin n_err++; $display("FAIL rd_full_stable: got %0d expected 0", stab_err); end
    endtask

    task automatic test_write_low();
        int ack; logic [31:0] rd;
        wb_xfer(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'b0011, -1, 60, ack, rd);
        n_cmp++; if (ack !== 8) begin n_err++; $display("FAIL wr_lo_ack: got %0d expected 8", ack); end
        n_cmp++; if (we_lo !== 5) begin n_err++; $display("FAIL wr_lo_we: got %0d expected 5", we_lo); end
        n_cmp++; if (ce_falls !== 1) begin n_err++; $display("FAIL wr_lo_ce: got %0d expected 1", ce_falls); end
        n_cmp++; if (acc_addr !== 23'd3) begin n_err++; $display("FAIL wr_lo_addr: got %0d expected 3", acc_addr); end
        n_cmp++; if ({acc_ub_n, acc_lb_n} !== 2'b00) begin n_err++; $display("FAIL wr_lo_lanes: got %b expected 00", {acc_ub_n, acc_lb_n}); end
        n_cmp++; if (acc_dq !== 16'hBEEF) begin n_err++; $display("FAIL wr_lo_dq: got %h expected beef", acc_dq); end
        n_cmp++; if (mem[3] !== 16'hBEEF) begin n_err++; $display("FAIL wr_lo_mem: got %h expected beef", mem[3]); end
    endtask

    task automatic test_write_hi_byte();
        int ack; logic [31:0] rd;
        wb_xfer(1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'b1000, -1, 60, ack, rd);
        n_cmp++; if (ack !== 8) begin n_err++; $display("FAIL wr_hb_ack: got %0d expected 8", ack); end
        n_cmp++; if (ce_falls !== 1) begin n_err++; $display("FAIL wr_hb_ce: got %0d expected 1", ce_falls); end
        n_cmp++; if (acc_addr !== 23'd0) begin n_err++; $display("FAIL wr_hb_addr: got %0d expected 0", acc_addr); end
        n_cmp++; if ({acc_ub_n, acc_lb_n} !== 2'b01) begin n_err++; $display("FAIL wr_hb_lanes: got %b expected 01", {acc_ub_n, acc_lb_n}); end
        n_cmp++; if (acc_dq !== 16'hDEAD) begin n_err++; $display("FAIL wr_hb_dq: got %h expected dead", acc_dq); end
        n_cmp++; if (mem[0] !== 16'hDE55) begin n_err++; $display("FAIL wr_hb_mem0: got %h expected de55", mem[0]); end
        n_cmp++; if (mem[1] !== 16'h0000) begin n_err++; $display("FAIL wr_hb_mem1: got %h expected 0000", mem[1]); end
    endtask

    task automatic test_read_sel0();
        int ack; logic [31:0] rd;
        wb_xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, -1, 60, ack, rd);
        n_cmp++; if (ack !== 1) begin n_err++; $display("FAIL sel0_ack: got %0d expected 1", ack); end
        n_cmp++; if (ce_falls !== 0) begin n_err++; $display("FAIL sel0_ce: got %0d expected 0", ce_falls); end
        n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL sel0_dat: got %h expected 0", rd); end
    endtask

    task automatic test_read_half();
        int ack; logic [31:0] rd;
        wb_xfer(1'b0, 32'h0000_0010, 32'h0, 4'b0001, -1, 60, ack, rd);
        n_cmp++; if (ack !== 6) begin n_err++; $display("FAIL rd_half_ack: got %0d expected 6", ack); end
        n_cmp++; if (rd !== 32'h0000_ABCD) begin n_err++; $display("FAIL rd_half_dat: got %h expected 0000abcd", rd); end
        n_cmp++; if (oe_lo !== 5) begin n_err++; $display("FAIL rd_half_oe: got %0d expected 5", oe_lo); end
        n_cmp++; if (acc_addr !== 23'd9) begin n_err++; $display("FAIL rd_half_addr: got %0d expected 9", acc_addr); end
        n_cmp++; if ({acc_ub_n, acc_lb_n} !== 2'b10) begin n_err++; $display("FAIL rd_half_lanes: got %b expected 10", {acc_ub_n, acc_lb_n}); end
    endtask

    task automatic test_write_full();
        int ack; logic [31:0] rd;
        wb_xfer(1'b1, 32'h0000_0008, 32'h1122_3344, 4'hF, -1, 60, ack, rd);
        n_cmp++; if (ack !== 16) begin n_err++; $display("FAIL wr_full_ack: got %0d expected 16", ack); end
        n_cmp++; if (we_lo !== 10) begin n_err++; $display("FAIL wr_full_we: got %0d expected 10", we_lo); end
        n_cmp++; if (mem[4] !== 16'h1122) begin n_err++; $display("FAIL wr_full_mem4: got %h expected 1122", mem[4]); end
        n_cmp++; if (mem[5] !== 16'h3344) begin n_err++; $display("FAIL wr_full_mem5: got %h expected 3344", mem[5]); end
        n_cmp++; if (stab_err !== 0) begin n_err++; $display("FAIL wr_full_stable: got %0d expected 0", stab_err); end
    endtask

    task automatic test_abort();
        int ack; logic [31:0] rd;
        wb_xfer(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 3, 40, ack, rd);
        n_cmp++; if (ack !== -1) begin n_err++; $display("FAIL abort_noack: got %0d expected -1", ack); end
        n_cmp++; if (ce_falls !== 1) begin n_err++; $display("FAIL abort_ce: got %0d expected 1", ce_falls); end
        n_cmp++; if (we_lo !== 5) begin n_err++; $display("FAIL abort_we: got %0d expected 5", we_lo); end
        n_cmp++; if (mem[16] !== 16'hCAFE) begin n_err++; $display("FAIL abort_mem16: got %h expected cafe", mem[16]); end
        n_cmp++; if (mem[17] !== 16'h0000) begin n_err++; $display("FAIL abort_mem17: got %h expected 0000", mem[17]); end
        wb_xfer(1'b0, 32'h0, 32'h0, 4'h0, -1, 60, ack, rd);
        n_cmp++; if (ack !== 1) begin n_err++; $display("FAIL abort_idle: got %0d expected 1", ack); end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  map0;
        logic [15:0] map1;
        map0 = '0; map1 = '0;
        @(posedge wb_clk); #1;
        wb.wb_we_i = 1'b0; wb.wb_sel_i = 4'h0; wb.wb_adr_i = 32'h0;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge wb_clk); map0[k] = wb.wb_ack_o;
            @(posedge wb_clk); #1;
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        n_cmp++; if (map0 !== 9'b010010010) begin n_err++; $display("FAIL b2b_sel0_acks: got %b expected 010010010", map0); end
        repeat (4) @(posedge wb_clk);
        #1;
        ce_falls = 0;
        wb.wb_sel_i = 4'b1100; wb.wb_adr_i = 32'h0000_0010;
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge wb_clk); map1[k] = wb.wb_ack_o;
            @(posedge wb_clk); #1;
        end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        n_cmp++; if (map1 !== 16'h4040) begin n_err++; $display("FAIL b2b_rd_acks: got %h expected 4040", map1); end
        n_cmp++; if (ce_falls !== 2) begin n_err++; $display("FAIL b2b_rd_ce: got %0d expected 2", ce_falls); end
        repeat (4) @(posedge wb_clk);
    endtask

    task automatic test_reset_mid();
        int ack; logic [31:0] rd;
        @(posedge wb_clk); #1;
        wb.wb_adr_i = 32'h0000_0030; wb.wb_dat_i = 32'h55AA_66BB; wb.wb_sel_i = 4'hF;
        wb.wb_we_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1;
        repeat (3) @(posedge wb_clk);
        #2;
        n_cmp++; if ({mem_we_n, mem_ce_n, mem_dq_oe} !== 3'b001) begin n_err++; $display("FAIL rmid_in_pulse: got %b expected 001", {mem_we_n, mem_ce_n, mem_dq_oe}); end
        wb_rst = 1'b1;
        #1;
        n_cmp++; if ({mem_we_n, mem_ce_n, mem_oe_n} !== 3'b111) begin n_err++; $display("FAIL rmid_strobes: got %b expected 111", {mem_we_n, mem_ce_n, mem_oe_n}); end
        n_cmp++; if (mem_dq_oe !== 1'b0) begin n_err++; $display("FAIL rmid_dq_oe: got %b expected 0", mem_dq_oe); end
        n_cmp++; if (wb.wb_ack_o !== 1'b0) begin n_err++; $display("FAIL rmid_ack: got %b expected 0", wb.wb_ack_o); end
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        @(negedge wb_clk);
        wb_rst = 1'b0;
`ifdef CELLRAM_PWRUP_WAIT_EN
        wb_xfer(1'b0, 32'h0, 32'h0, 4'h0, -1, 8000, ack, rd);
        n_cmp++; if (ack < 7499 || ack > 7502) begin n_err++; $display("FAIL rmid_pwrup: got %0d expected about 7500", ack); end
`else
        wb_xfer(1'b0, 32'h0, 32'h0, 4'h0, -1, 60, ack, rd);
        n_cmp++; if (ack !== 1) begin n_err++; $display("FAIL rmid_recover: got %0d expected 1", ack); end
`endif
    endtask

    initial begin
        wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_sel_i = '0;
        wb.wb_we_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[0] = 16'h5555;
        mem[8] = 16'h1234;
        mem[9] = 16'hABCD;
        test_reset();
        test_read_full();
        test_write_low();
        test_write_hi_byte();
        test_read_sel0();
        test_read_half();
        test_write_full();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
